// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM states, FIFO entry layout and PC step.
package bru_pkg;

    localparam int unsigned PC_INC   = 4;
    localparam int unsigned DEF_PC_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Default-width entry layout; the top re-declares it at its own PC_W.
    typedef struct packed {
        logic [DEF_PC_W-1:0] pc;
        logic                taken;
        logic [DEF_PC_W-1:0] target;
    } entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction log, resolve, predictor update and redirect signals of the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DEPTH  = 4
);
    logic                     pred_valid;
    logic                     pred_ready;
    logic [PC_W-1:0]          pred_pc;
    logic                     pred_taken;
    logic [PC_W-1:0]          pred_target;
    logic                     res_valid;
    logic                     res_taken;
    logic [PC_W-1:0]          res_target;
    logic                     upd_valid;
    logic [ADDR_W-1:0]        upd_address;
    logic                     upd_taken;
    logic                     redirect_valid;
    logic [PC_W-1:0]          redirect_pc;
    logic [$clog2(DEPTH):0]   inflight;
    logic [CNT_W-1:0]         branch_cnt;
    logic [CNT_W-1:0]         mispredict_cnt;
    logic                     res_err;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, upd_valid, upd_address, upd_taken,
        input  redirect_valid, redirect_pc, inflight,
        input  branch_cnt, mispredict_cnt, res_err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, upd_valid, upd_address, upd_taken,
        output redirect_valid, redirect_pc, inflight,
        output branch_cnt, mispredict_cnt, res_err
    );

endinterface

// File: rtl/bru_fifo.sv
// In-order FIFO of predicted branches; flush empties it and wins over push/pop, no bypass.
module bru_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = bru_pkg::entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 din,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the oldest predicted branch, trains the predictor and redirects fetch on mispredict.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } bru_entry_t;

    state_t                 state_q;
    state_t                 state_d;
    bru_entry_t             din;
    bru_entry_t             head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   push_fire;
    logic                   resolve;
    logic                   mispredict;
    logic                   flush;
    logic [PC_W-1:0]        correct_pc;

    logic                   upd_valid_q;
    logic [ADDR_W-1:0]      upd_address_q;
    logic                   upd_taken_q;
    logic                   redirect_valid_q;
    logic [PC_W-1:0]        redirect_pc_q;
    logic [CNT_W-1:0]       branch_cnt_q;
    logic [CNT_W-1:0]       mispredict_cnt_q;
    logic                   res_err_q;

    assign bus.pred_ready = (state_q == RUN) && !full;
    assign push_fire      = bus.pred_valid && bus.pred_ready;
    assign resolve        = bus.res_valid && (state_q == RUN) && !empty;
    assign mispredict     = (head.taken != bus.res_taken) ||
                            (bus.res_taken && (head.target != bus.res_target));
    assign flush          = resolve && mispredict;
    assign correct_pc     = bus.res_taken ? bus.res_target : head.pc + PC_W'(PC_INC);

    assign din.pc     = bus.pred_pc;
    assign din.taken  = bus.pred_taken;
    assign din.target = bus.pred_target;

    // A mispredict flush also swallows the same-cycle (wrong-path) push inside the FIFO.
    bru_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (bru_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_fire),
        .pop   (resolve),
        .flush (flush),
        .din   (din),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q      <= 1'b0;
            upd_address_q    <= '0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            res_err_q        <= 1'b0;
        end else begin
            upd_valid_q      <= resolve;
            redirect_valid_q <= flush;
            if (resolve) begin
                upd_address_q <= head.pc[ADDR_W-1:0];
                upd_taken_q   <= bus.res_taken;
                if (branch_cnt_q != '1) begin
                    branch_cnt_q <= branch_cnt_q + CNT_W'(1);
                end
            end
            if (flush) begin
                redirect_pc_q <= correct_pc;
                if (mispredict_cnt_q != '1) begin
                    mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
                end
            end
            if (bus.res_valid && (state_q == RUN) && empty) begin
                res_err_q <= 1'b1;
            end
        end
    end

    assign bus.upd_valid      = upd_valid_q;
    assign bus.upd_address    = upd_address_q;
    assign bus.upd_taken      = upd_taken_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.inflight       = count;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;
    assign bus.res_err        = res_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a reference queue and an expected-update scoreboard.
module tb_branch_resolve_unit;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        logic [7:0]  addr;
        logic        taken;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    ent_t        mq[$];
    exp_t        sb[$];
    bit          flush_m;
    bit          err_m;
    int unsigned bcnt;
    int unsigned mcnt;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(
        .PC_W   (PC_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .DEPTH  (DEPTH)
    ) bus ();

    branch_resolve_unit #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        flush_m = 1'b0;
        err_m   = 1'b0;
        bcnt    = 0;
        mcnt    = 0;
    endtask

    task automatic check_out();
        exp_t e;
        chk("upd_valid", bus.upd_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("upd_address", bus.upd_address, e.addr);
            chk("upd_taken", bus.upd_taken, e.taken);
            chk("redirect_valid", bus.redirect_valid, e.redir);
            if (e.redir) chk("redirect_pc", bus.redirect_pc, e.rpc);
        end else begin
            chk("redirect_idle", bus.redirect_valid, 1'b0);
        end
        chk("inflight", bus.inflight, mq.size());
        chk("pred_ready", bus.pred_ready, !flush_m && (mq.size() < DEPTH));
        chk("branch_cnt", bus.branch_cnt, bcnt);
        chk("mispredict_cnt", bus.mispredict_cnt, mcnt);
        chk("res_err", bus.res_err, err_m);
    endtask

    // One clock of stimulus: predicts the outcome from the reference queue, then checks after the edge.
    task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                        input bit rv, input bit rt, input logic [31:0] rtg);
        bit          rdy;
        bit          acc;
        bit          mis;
        ent_t        h;
        exp_t        e;
        logic [31:0] cpc;
        rdy = !flush_m && (mq.size() < DEPTH);
        chk("pred_ready_pre", bus.pred_ready, rdy);
        bus.pred_valid  = pv;
        bus.pred_pc     = pc;
        bus.pred_taken  = pt;
        bus.pred_target = ptg;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtg;
        acc = pv && rdy;
        if (rv && !flush_m && mq.size() == 0) err_m = 1'b1;
        if (rv && !flush_m && mq.size() > 0) begin
            flush_m = 1'b0;
            h   = mq.pop_front();
            mis = (h.taken != rt) || (rt && (h.target != rtg));
            cpc = rt ? rtg : h.pc + 32'd4;
            e.addr  = h.pc[7:0];
            e.taken = rt;
            e.redir = mis;
            e.rpc   = cpc;
            sb.push_back(e);
            if (bcnt < 32'hFFFF) bcnt++;
            if (mis) begin
                if (mcnt < 32'hFFFF) mcnt++;
                mq.delete();
                flush_m = 1'b1;
                acc = 1'b0;
            end
        end else begin
            flush_m = 1'b0;
        end
        if (acc) mq.push_back('{pc, pt, ptg});
        @(posedge clk);
        #1;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        check_out();
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        bus.pred_valid  = 1'b0;
        bus.pred_pc     = '0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.res_target  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out();
        chk("reset_redirect_pc", bus.redirect_pc, 32'h0);
        rst_n = 1'b1;

        // Correct taken prediction
        step(1, 32'h100, 1, 32'h200, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h200);

        // Direction mispredict, then FLUSH cycle
        step(1, 32'h1A4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h300);
        step(0, 0, 0, 0, 0, 0, 0);

        // Predicted taken, actually not taken: fall-through redirect
        step(1, 32'h40, 1, 32'h80, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Direction right, target wrong
        step(1, 32'h500, 1, 32'h600, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h604);
        step(0, 0, 0, 0, 0, 0, 0);

        // Fill, refused push while full, then cross pointer wrap
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h1000 + i * 16, i[0], 32'h2000 + i * 16, 0, 0, 0);
        end
        step(1, 32'h1100, 0, 0, 1, mq[0].taken, mq[0].target);
        for (int i = 0; i < 7; i++) begin
            step(1, 32'h1200 + i * 8, (i % 3) == 0, 32'h3000 + i * 4, 1, mq[0].taken, mq[0].target);
        end
        while (mq.size() > 0) begin
            step(0, 0, 0, 0, 1, mq[0].taken, mq[0].target);
        end

        // Mispredict on head of three with simultaneous push; FLUSH ignores resolve and push
        step(1, 32'h700, 0, 0, 0, 0, 0);
        step(1, 32'h708, 0, 0, 0, 0, 0);
        step(1, 32'h710, 0, 0, 0, 0, 0);
        step(1, 32'h7FC, 0, 0, 1, 1, 32'h900);
        step(1, 32'h800, 0, 0, 1, 1, 32'h900);
        step(0, 0, 0, 0, 0, 0, 0);

        // Resolve while empty
        step(0, 0, 0, 0, 1, 1, 32'h123);
        step(0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-stream with a resolve pending
        step(1, 32'hA00, 1, 32'hB00, 0, 0, 0);
        step(1, 32'hA08, 0, 0, 0, 0, 0);
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b0;
        bus.res_target = '0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_out();
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_upd_address", bus.upd_address, 8'h0);
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        check_out();
        rst_n = 1'b1;

        // Normal operation after reset
        step(1, 32'hC10, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
